// File: rtl/cla_pkg.sv
// Shared constants, sizing helpers and per-stage control payload for the
// pipelined carry-lookahead adder.
package cla_pkg;

    localparam int unsigned GROUP_W = 4;

    function automatic int unsigned num_groups(input int unsigned width);
        return width / GROUP_W;
    endfunction

    function automatic bit width_ok(input int unsigned width);
        return (width >= GROUP_W) && ((width % GROUP_W) == 0);
    endfunction

    // Per-stage control. The width-dependent partial result and remaining
    // operand slices live alongside this in the top, sized by WIDTH.
    typedef struct packed {
        logic valid;
        logic carry;
        logic msb_carry;
    } stage_t;

endpackage

// File: rtl/cla_adder_pipe_group4.sv
// Combinational 4-bit carry-lookahead group: sum, carry-out, carry into
// bit 3 (for signed overflow) and group generate/propagate.
module cla_group4
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a_i,
    input  logic [GROUP_W-1:0] b_i,
    input  logic               cin_i,
    output logic [GROUP_W-1:0] sum_o,
    output logic               cout_o,
    output logic               c3_o,
    output logic               g_o,
    output logic               p_o
);

    logic [GROUP_W-1:0] g;
    logic [GROUP_W-1:0] p;
    logic [GROUP_W-1:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Flattened lookahead equations: every carry is two gate levels deep.
    assign c[0] = cin_i;
    assign c[1] = g[0] | (p[0] & cin_i);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin_i);

    assign g_o    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0]);
    assign p_o    = &p;
    assign cout_o = g_o | (p_o & cin_i);
    assign c3_o   = c[3];
    assign sum_o  = p ^ c;

endmodule

// File: rtl/cla_adder_pipe.sv
// WIDTH-bit pipelined add/subtract: one 4-bit lookahead group per stage,
// group carries registered between stages, valid/ready with global stall.
module cla_adder_pipe
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int unsigned NG        = num_groups(WIDTH);
    localparam int unsigned TOP_SHIFT = WIDTH - GROUP_W;

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("cla_adder_pipe: WIDTH=%0d must be a positive multiple of %0d",
               WIDTH, GROUP_W);
    end

    logic               en;
    logic [WIDTH-1:0]   b_eff;
    logic               cin_eff;

    logic [GROUP_W-1:0] grp_a    [NG];
    logic [GROUP_W-1:0] grp_b    [NG];
    logic               grp_cin  [NG];
    logic [GROUP_W-1:0] grp_sum  [NG];
    logic               grp_cout [NG];
    logic               grp_c3   [NG];
    logic               grp_g    [NG];
    logic               grp_p    [NG];

    stage_t             stg_q    [NG];
    stage_t             stg_d    [NG];
    logic [WIDTH-1:0]   res_q    [NG];
    logic [WIDTH-1:0]   res_d    [NG];
    logic [WIDTH-1:0]   opa_q    [NG];
    logic [WIDTH-1:0]   opa_d    [NG];
    logic [WIDTH-1:0]   opb_q    [NG];
    logic [WIDTH-1:0]   opb_d    [NG];

    logic               unused_bits;

    // Whole pipeline moves as one; in_ready never looks at in_valid.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Subtract as a + ~b + ~c_in, i.e. a - b - c_in.
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = c_in ^ sub;

    for (genvar k = 0; k < NG; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign grp_a[k]   = a[GROUP_W-1:0];
            assign grp_b[k]   = b_eff[GROUP_W-1:0];
            assign grp_cin[k] = cin_eff;
        end else begin : g_next
            assign grp_a[k]   = opa_q[k-1][GROUP_W-1:0];
            assign grp_b[k]   = opb_q[k-1][GROUP_W-1:0];
            assign grp_cin[k] = stg_q[k-1].carry;
        end

        cla_group4 u_group (
            .a_i    (grp_a[k]),
            .b_i    (grp_b[k]),
            .cin_i  (grp_cin[k]),
            .sum_o  (grp_sum[k]),
            .cout_o (grp_cout[k]),
            .c3_o   (grp_c3[k]),
            .g_o    (grp_g[k]),
            .p_o    (grp_p[k])
        );
    end

    // Result slices enter at the top and shift down; operands shift down so
    // the next group always reads the low nibble.
    always_comb begin
        stg_d[0].valid     = in_valid;
        stg_d[0].carry     = grp_cout[0];
        stg_d[0].msb_carry = grp_c3[0];
        res_d[0]           = WIDTH'(grp_sum[0]) << TOP_SHIFT;
        opa_d[0]           = a >> GROUP_W;
        opb_d[0]           = b_eff >> GROUP_W;
        for (int unsigned k = 1; k < NG; k++) begin
            stg_d[k].valid     = stg_q[k-1].valid;
            stg_d[k].carry     = grp_cout[k];
            stg_d[k].msb_carry = grp_c3[k];
            res_d[k]           = (res_q[k-1] >> GROUP_W)
                               | (WIDTH'(grp_sum[k]) << TOP_SHIFT);
            opa_d[k]           = opa_q[k-1] >> GROUP_W;
            opb_d[k]           = opb_q[k-1] >> GROUP_W;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < NG; k++) begin
                stg_q[k] <= '0;
                res_q[k] <= '0;
                opa_q[k] <= '0;
                opb_q[k] <= '0;
            end
        end else if (en) begin
            for (int unsigned k = 0; k < NG; k++) begin
                stg_q[k] <= stg_d[k];
                res_q[k] <= res_d[k];
                opa_q[k] <= opa_d[k];
                opb_q[k] <= opb_d[k];
            end
        end
    end

    // Group g/p serve multi-level lookahead, unneeded with per-stage carries;
    // the last stage has no further operands to consume.
    always_comb begin
        unused_bits = ^{opa_q[NG-1], opb_q[NG-1]};
        for (int unsigned k = 0; k < NG; k++) begin
            unused_bits = unused_bits ^ grp_g[k] ^ grp_p[k] ^ stg_q[k].msb_carry;
        end
    end

    assign out_valid = stg_q[NG-1].valid;
    assign sum       = res_q[NG-1];
    assign c_out     = stg_q[NG-1].carry;
    assign ovf       = stg_q[NG-1].carry ^ stg_q[NG-1].msb_carry;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Scoreboarded bench for cla_adder_pipe: WIDTH=16 and WIDTH=4 instances.
module tb_cla_adder_pipe;

    localparam int unsigned W       = 16;
    localparam int unsigned W1      = W + 1;
    localparam int unsigned W4      = 4;
    localparam int unsigned W41     = W4 + 1;
    localparam int unsigned TIMEOUT = 50;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          c_in = 1'b0;
    logic          sub = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  sum;
    logic          c_out;
    logic          ovf;

    logic          w4_in_valid = 1'b0;
    logic          w4_in_ready;
    logic [W4-1:0] w4_a = '0;
    logic [W4-1:0] w4_b = '0;
    logic          w4_c_in = 1'b0;
    logic          w4_sub = 1'b0;
    logic          w4_out_valid;
    logic          w4_out_ready = 1'b0;
    logic [W4-1:0] w4_sum;
    logic          w4_c_out;
    logic          w4_ovf;

    int            n_vec = 0;
    int            n_err = 0;
    int            got16 = 0;
    int            got4  = 0;

    // Scoreboard entries are {c_out, sum, ovf}.
    logic [W+1:0]  q16 [$];
    logic [W4+1:0] q4  [$];
    logic [W+1:0]  exp16;
    logic [W4+1:0] exp4;

    always #5 clk = ~clk;

    cla_adder_pipe #(.WIDTH(W)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    cla_adder_pipe #(.WIDTH(W4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w4_in_valid),
        .in_ready  (w4_in_ready),
        .a         (w4_a),
        .b         (w4_b),
        .c_in      (w4_c_in),
        .sub       (w4_sub),
        .out_valid (w4_out_valid),
        .out_ready (w4_out_ready),
        .sum       (w4_sum),
        .c_out     (w4_c_out),
        .ovf       (w4_ovf)
    );

    // Signed overflow from operand/result signs, carry-out from a wide add.
    function automatic logic [W+1:0] model16(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic ci, input logic s);
        logic [W-1:0] ye;
        logic [W:0]   full;
        ye   = s ? ~y : y;
        full = W1'(x) + W1'(ye) + W1'(ci ^ s);
        return {full, (x[W-1] == ye[W-1]) && (full[W-1] != x[W-1])};
    endfunction

    function automatic logic [W4+1:0] model4(input logic [W4-1:0] x, input logic [W4-1:0] y,
                                             input logic ci, input logic s);
        logic [W4-1:0] ye;
        logic [W4:0]   full;
        ye   = s ? ~y : y;
        full = W41'(x) + W41'(ye) + W41'(ci ^ s);
        return {full, (x[W4-1] == ye[W4-1]) && (full[W4-1] != x[W4-1])};
    endfunction

    // Handshakes are sampled mid-cycle; inputs only change just after posedge.
    always @(negedge clk) begin
        if (rst) begin
            q16.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_vec++;
                got16++;
                if (q16.size() == 0) begin
                    n_err++;
                    $display("FAIL out16_unexpected: got sum=%h c_out=%b ovf=%b, required no output",
                             sum, c_out, ovf);
                end else begin
                    exp16 = q16.pop_front();
                    if ({c_out, sum, ovf} !== exp16) begin
                        n_err++;
                        $display("FAIL out16_data: got c_out=%b sum=%h ovf=%b, required c_out=%b sum=%h ovf=%b",
                                 c_out, sum, ovf, exp16[W+1], exp16[W:1], exp16[0]);
                    end
                end
            end
            if (in_valid && in_ready) q16.push_back(model16(a, b, c_in, sub));
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            q4.delete();
        end else begin
            if (w4_out_valid && w4_out_ready) begin
                n_vec++;
                got4++;
                if (q4.size() == 0) begin
                    n_err++;
                    $display("FAIL out4_unexpected: got sum=%h c_out=%b ovf=%b, required no output",
                             w4_sum, w4_c_out, w4_ovf);
                end else begin
                    exp4 = q4.pop_front();
                    if ({w4_c_out, w4_sum, w4_ovf} !== exp4) begin
                        n_err++;
                        $display("FAIL out4_data: got c_out=%b sum=%h ovf=%b, required c_out=%b sum=%h ovf=%b",
                                 w4_c_out, w4_sum, w4_ovf, exp4[W4+1], exp4[W4:1], exp4[0]);
                    end
                end
            end
            if (w4_in_valid && w4_in_ready) q4.push_back(model4(w4_a, w4_b, w4_c_in, w4_sub));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send16(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input logic s);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        c_in     = ci;
        sub      = s;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out16(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_vec++;
        if ({out_valid, sum, c_out, ovf} !== '0) begin
            n_err++;
            $display("FAIL reset16_outputs: got valid=%b sum=%h c_out=%b ovf=%b, required all 0",
                     out_valid, sum, c_out, ovf);
        end
        n_vec++;
        if ({w4_out_valid, w4_sum, w4_c_out, w4_ovf} !== '0) begin
            n_err++;
            $display("FAIL reset4_outputs: got valid=%b sum=%h c_out=%b ovf=%b, required all 0",
                     w4_out_valid, w4_sum, w4_c_out, w4_ovf);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if ({in_ready, w4_in_ready} !== 2'b11) begin
            n_err++;
            $display("FAIL reset_in_ready: got in_ready=%b w4_in_ready=%b, required 1 1",
                     in_ready, w4_in_ready);
        end
    endtask

    task automatic test_add_latency();
        out_ready = 1'b1;
        send16(16'h0005, 16'h0003, 1'b0, 1'b0);
        for (int e = 1; e <= 4; e++) begin
            n_vec++;
            if (out_valid !== (e == 4)) begin
                n_err++;
                $display("FAIL add_latency edge %0d: got out_valid=%b, required %b",
                         e, out_valid, (e == 4));
            end
            if (e < 4) tick();
        end
        n_vec++;
        if ({sum, c_out, ovf} !== {16'h0008, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL add_result: got sum=%h c_out=%b ovf=%b, required sum=0008 c_out=0 ovf=0",
                     sum, c_out, ovf);
        end
        tick();
    endtask

    task automatic test_carry_chain();
        logic [W-1:0] ta [3];
        logic [W-1:0] tb [3];
        logic [W+1:0] te [3];
        bit           ok;
        ta = '{16'hFFFF, 16'h7FFF, 16'h0FFF};
        tb = '{16'h0001, 16'h0001, 16'h0001};
        te = '{{1'b1, 16'h0000, 1'b0}, {1'b0, 16'h8000, 1'b1}, {1'b0, 16'h1000, 1'b0}};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send16(ta[i], tb[i], 1'b0, 1'b0);
            wait_out16(ok);
            n_vec++;
            if (!ok) begin
                n_err++;
                $display("FAIL carry_timeout %0d: got no out_valid, required result", i);
            end else if ({c_out, sum, ovf} !== te[i]) begin
                n_err++;
                $display("FAIL carry %0d: got c_out=%b sum=%h ovf=%b, required c_out=%b sum=%h ovf=%b",
                         i, c_out, sum, ovf, te[i][W+1], te[i][W:1], te[i][0]);
            end
            tick();
        end
    endtask

    task automatic test_subtract();
        logic [W-1:0] ta [3];
        logic [W-1:0] tb [3];
        logic         tc [3];
        logic [W+1:0] te [3];
        bit           ok;
        ta = '{16'h0005, 16'h8000, 16'h0010};
        tb = '{16'h0007, 16'h0001, 16'h0001};
        tc = '{1'b0, 1'b0, 1'b1};
        te = '{{1'b0, 16'hFFFE, 1'b0}, {1'b1, 16'h7FFF, 1'b1}, {1'b1, 16'h000E, 1'b0}};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send16(ta[i], tb[i], tc[i], 1'b1);
            wait_out16(ok);
            n_vec++;
            if (!ok) begin
                n_err++;
                $display("FAIL sub_timeout %0d: got no out_valid, required result", i);
            end else if ({c_out, sum, ovf} !== te[i]) begin
                n_err++;
                $display("FAIL sub %0d: got c_out=%b sum=%h ovf=%b, required c_out=%b sum=%h ovf=%b",
                         i, c_out, sum, ovf, te[i][W+1], te[i][W:1], te[i][0]);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            a        = W'(32'h1111 * (i + 1));
            b        = W'(32'h1111 * (i + 1));
            c_in     = 1'b0;
            sub      = 1'b0;
            tick();
        end
        // Offer a transaction during the stall; it must not be taken.
        in_valid  = 1'b1;
        a         = 16'hDEAD;
        b         = 16'hBEEF;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || sum !== 16'h2222) begin
                n_err++;
                $display("FAIL stall cycle %0d: got in_ready=%b out_valid=%b sum=%h, required 0 1 2222",
                         i, in_ready, out_valid, sum);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++;
            if (out_valid !== 1'b1 || sum !== W'(32'h2222 * (i + 1))) begin
                n_err++;
                $display("FAIL drain %0d: got out_valid=%b sum=%h, required 1 %h",
                         i, out_valid, sum, W'(32'h2222 * (i + 1)));
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        int base;
        out_ready = 1'b1;
        send16(16'h1234, 16'h1111, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || sum !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs: got out_valid=%b sum=%h, required 0 0000", out_valid, sum);
        end
        tick();
        base = got16;
        rst  = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_in_ready: got %b, required 1", in_ready);
        end
        repeat (8) tick();
        n_vec++;
        if (got16 != base || q16.size() != 0) begin
            n_err++;
            $display("FAIL midreset_ghost: got %0d results after reset, required 0", got16 - base);
        end
    endtask

    task automatic test_width4();
        logic [W4-1:0] ta [2];
        logic [W4-1:0] tb [2];
        logic          tc [2];
        logic          ts [2];
        logic [W4+1:0] te [2];
        ta = '{4'hC, 4'h3};
        tb = '{4'hA, 4'h5};
        tc = '{1'b1, 1'b0};
        ts = '{1'b0, 1'b1};
        // -4 + -6 + 1 = -9 does not fit in 4 signed bits.
        te = '{{1'b1, 4'h7, 1'b1}, {1'b0, 4'hE, 1'b0}};
        w4_out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            w4_in_valid = 1'b1;
            w4_a        = ta[i];
            w4_b        = tb[i];
            w4_c_in     = tc[i];
            w4_sub      = ts[i];
            tick();
            w4_in_valid = 1'b0;
            n_vec++;
            if (w4_out_valid !== 1'b1 || {w4_c_out, w4_sum, w4_ovf} !== te[i]) begin
                n_err++;
                $display("FAIL w4 %0d: got valid=%b c_out=%b sum=%h ovf=%b, required valid=1 c_out=%b sum=%h ovf=%b",
                         i, w4_out_valid, w4_c_out, w4_sum, w4_ovf, te[i][W4+1], te[i][W4:1], te[i][0]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 200; i++) begin
            in_valid     = ($urandom_range(0, 3) != 0);
            a            = W'($urandom);
            b            = W'($urandom);
            c_in         = 1'($urandom);
            sub          = 1'($urandom);
            out_ready    = ($urandom_range(0, 3) != 0);
            w4_in_valid  = ($urandom_range(0, 3) != 0);
            w4_a         = W4'($urandom);
            w4_b         = W4'($urandom);
            w4_c_in      = 1'($urandom);
            w4_sub       = 1'($urandom);
            w4_out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid     = 1'b0;
        w4_in_valid  = 1'b0;
        out_ready    = 1'b1;
        w4_out_ready = 1'b1;
        for (int i = 0; i < TIMEOUT && (q16.size() != 0 || q4.size() != 0); i++) tick();
        n_vec++;
        if (q16.size() != 0) begin
            n_err++;
            $display("FAIL drain16: got %0d results outstanding, required 0", q16.size());
        end
        n_vec++;
        if (q4.size() != 0) begin
            n_err++;
            $display("FAIL drain4: got %0d results outstanding, required 0", q4.size());
        end
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_carry_chain();
        test_subtract();
        test_backpressure();
        test_reset_midflight();
        test_width4();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
